vcmac_seq: RTL and testbench
============================

# vcmac_seq

Row sequencer that sits directly upstream of the vector complex MAC (VCMAC) and turns a stream of operand beats into complex matrix-vector products. It issues K beats per output row: one multiply beat, then K-1 accumulate beats. It then waits one cycle for the MAC result register, captures the N-lane result and overflow, and presents them on a valid/ready output. It owns every VCMAC control input (`mult`, `acc`, `w_en`, `abs`) and forwards operands combinationally.

## Interface
Parameters:
- `DATA_W`, 32, lane word width; matches VCMAC.
- `N`, 2, number of lanes; matches VCMAC.
- `K`, 4, beats (product terms) per output row; K ≥ 1.
- `M`, 4, rows per matrix; M ≥ 1; sets the row-index wrap point.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_A_r`, `in_A_i`, `in_B_r`, `in_B_i`  in  DATA_W×[N]  operand lanes.
- `in_abs`  in  1  abs mode for the row; sampled on the row's first beat only.
- `cm_A_r`, `cm_A_i`, `cm_B_r`, `cm_B_i`  out  DATA_W×[N]  to VCMAC operands.
- `cm_mult`, `cm_acc`, `cm_w_en`, `cm_abs`  out  1  to VCMAC controls.
- `cm_overflow`  in  1  from VCMAC.
- `cm_S_r`, `cm_S_i`  in  DATA_W×[N]  from VCMAC results.
- `out_valid`  out  1  row result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_S_r`, `out_S_i`  out  DATA_W×[N]  captured row result.
- `out_overflow`  out  1  overflow flag for the row.
- `out_row`  out  max(1,$clog2(M))  index of the presented row.
- `out_last`  out  1  presented row is row M-1.

## Operation
- States:
  - RUN: accepting beats.
  - DRAIN: one cycle; the VCMAC register holds the final row value.
  - OUT: holding the result for the consumer.
- Reset state is RUN with `k`=0 and `row`=0.
- RUN:
  - `in_ready`=1.
  - `cm_w_en` = `in_valid`.
  - `cm_mult` = `in_valid & (k==0)`.
  - `cm_acc` = `in_valid & (k!=0)`.
  - `cm_mult` and `cm_acc` are never both 1.
  - Operand outputs equal the inputs in every state.
  - `cm_abs` = `in_abs` when `k==0`, otherwise the latched `abs_q`.
  - `abs_q` is loaded on an accepted beat with `k==0`.
- On an accepted beat:
  - `k` increments.
  - When `k==K-1`, `k` returns to 0 and the state goes to DRAIN.
  - K=1: every beat is a mult beat and goes straight to DRAIN.
- DRAIN:
  - `in_ready`=0; all `cm_*` controls are 0.
  - At the end of the cycle, capture `cm_S_r`/`cm_S_i` into `out_S_*`, capture overflow (see Configuration), and go to OUT.
- OUT:
  - `out_valid`=1; `in_ready`=0; `cm_*` controls are 0.
  - All outputs are held stable until `out_ready`.
  - When `out_valid & out_ready`: `row` increments (M-1 wraps to 0) and the state goes to RUN.
  - Input is not accepted in the handshake cycle itself; the earliest next beat is the following cycle.
- `out_last` = (`row`==M-1), registered together with `out_row`.
- No arithmetic is done here. Result width and format are exactly those of VCMAC.

## Timing
- Reset values: `in_ready`=0 while `rst`=0, then 1 from the first cycle after release. All other outputs are 0: `out_valid`, `out_S_*`, `out_overflow`, `out_row`, `out_last`, and all `cm_*` controls.
- Beat to VCMAC: 0 cycles, combinational through the controls and operands.
- Row latency: the last beat is accepted at edge t, DRAIN covers t..t+1, and `out_valid` rises after edge t+1.
- Throughput: the row period is at least K+2 cycles (K beats, DRAIN, OUT handshake).
- `in_valid` low in RUN: no write to VCMAC, and `k` holds (bubble).
- `out_ready` held low: OUT is held indefinitely, and no beat is accepted.
- `rst` asserted mid-row: immediate return to reset values. The partial row is discarded, and the next beat is treated as a mult beat.

## Configuration
- `VCMAC_SEQ_OVF_STICKY_EN` defined:
  - A sticky flag `ovf_q` is cleared on each accepted mult beat.
  - It is OR-ed with `cm_overflow` every cycle from the cycle after the mult beat through DRAIN.
  - `out_overflow` = `ovf_q` captured at DRAIN.
- Not defined: `out_overflow` = `cm_overflow` sampled in the DRAIN cycle only.

## Structure
- The shared package `vcmac_pkg` holds:
  - the state enum `vcmac_seq_state_t` {RUN, DRAIN, OUT};
  - the lane word typedef `lane_t` (logic [DATA_W-1:0]).
- No sub-module: a single module with one FSM, two counters, and the capture registers. The bench instantiates VCMAC alongside it.

## Test plan
All scenarios use N=2, DATA_W=32, M=2.

- **Reset:** hold `rst`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, all outputs 0, no `cm_w_en`. After release, `in_ready`=1.
- **K=3 row:** 3 back-to-back beats → `cm_mult` pattern 1,0,0 and `cm_acc` pattern 0,1,1. `out_valid` rises 2 edges after the 3rd beat, with `out_S_*` equal to the VCMAC reference model sum, `out_row`=0, `out_last`=0.
- **Bubbles and abs:** 3 beats with `in_valid` low between them, and `in_abs`=1 on beat 0 and 0 afterwards → `k` holds across bubbles, and `cm_abs`=1 on all 3 write beats.
- **Backpressure and wrap:** `out_ready`=0 for 5 cycles → `out_*` stable and `in_ready`=0. Complete 2 rows → `out_last`=1 on row 1, then `out_row` returns to 0.
- **Overflow:** force `cm_overflow`=1 for one cycle after beat 1 of 3 → `out_overflow`=1 with `VCMAC_SEQ_OVF_STICKY_EN` defined, 0 without.
- **Mid-row reset:** assert `rst` after beat 1 of 3 → outputs return to reset values, and the next beat asserts `cm_mult`=1.

Source files
------------

// File: rtl/vcmac_pkg.sv
// Shared definitions for the vector complex MAC (VCMAC) block family.
// Contents:
//   vcmac_seq_state_t : row-sequencer FSM states {RUN, DRAIN, OUT}
//   lane_t            : one VCMAC lane word at the default 32-bit width
//   idx_w()           : index width helper, never narrower than one bit
package vcmac_pkg;

  localparam int VCMAC_DATA_W = 32;

  typedef logic [VCMAC_DATA_W-1:0] lane_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } vcmac_seq_state_t;

  // Width of a counter/index covering 0..n-1, at least one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vcmac_seq.sv
// vcmac_seq: row sequencer in front of the vector complex MAC (VCMAC).
// It issues K operand beats per output row: one multiply beat, then K-1
// accumulate beats. It then waits one cycle (DRAIN) for the VCMAC result
// register to settle, captures the N-lane result and overflow, and presents
// them on a valid/ready output. It does no arithmetic itself.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   in_valid/in_ready        operand beat handshake
//   in_A_r..in_B_i           operand lanes, forwarded unchanged to cm_A_r..cm_B_i
//   in_abs                   abs mode, sampled on a row's first beat
//   cm_mult/acc/w_en/abs     VCMAC controls (combinational from the beat)
//   cm_overflow, cm_S_r/i    VCMAC status and result
//   out_valid/out_ready      row result handshake
//   out_S_r/i, out_overflow  captured row result and overflow
//   out_row, out_last        presented row index, and a flag for row M-1
//
// Build option:
//   VCMAC_SEQ_OVF_STICKY_EN  when defined, overflow is accumulated over the
//                            whole row (from the cycle after the mult beat
//                            through DRAIN). When undefined, only the DRAIN
//                            cycle's cm_overflow is captured.
module vcmac_seq
  import vcmac_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N      = 2,
  parameter int K      = 4,
  parameter int M      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0][DATA_W-1:0]  in_A_r,
  input  logic [N-1:0][DATA_W-1:0]  in_A_i,
  input  logic [N-1:0][DATA_W-1:0]  in_B_r,
  input  logic [N-1:0][DATA_W-1:0]  in_B_i,
  input  logic                      in_abs,
  output logic [N-1:0][DATA_W-1:0]  cm_A_r,
  output logic [N-1:0][DATA_W-1:0]  cm_A_i,
  output logic [N-1:0][DATA_W-1:0]  cm_B_r,
  output logic [N-1:0][DATA_W-1:0]  cm_B_i,
  output logic                      cm_mult,
  output logic                      cm_acc,
  output logic                      cm_w_en,
  output logic                      cm_abs,
  input  logic                      cm_overflow,
  input  logic [N-1:0][DATA_W-1:0]  cm_S_r,
  input  logic [N-1:0][DATA_W-1:0]  cm_S_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0][DATA_W-1:0]  out_S_r,
  output logic [N-1:0][DATA_W-1:0]  out_S_i,
  output logic                      out_overflow,
  output logic [idx_w(M)-1:0]       out_row,
  output logic                      out_last
);

  localparam int              KW     = idx_w(K);
  localparam int              RW     = idx_w(M);
  localparam logic [KW-1:0]   K_LAST = KW'(K - 1);
  localparam logic [RW-1:0]   M_LAST = RW'(M - 1);

  vcmac_seq_state_t           state_q, state_d;
  logic [KW-1:0]              k_q, k_d;
  logic [RW-1:0]              row_q, row_d;
  logic                       abs_q, abs_d;
  logic                       rdy_en_q;
  logic                       beat_s;
  logic                       first_s;
  logic                       ovf_cap_s;

  logic                       out_valid_q;
  logic [N-1:0][DATA_W-1:0]   out_s_r_q, out_s_i_q;
  logic                       out_ovf_q;
  logic [RW-1:0]              out_row_q;
  logic                       out_last_q;

  // Operands pass straight through in every state.
  assign cm_A_r = in_A_r;
  assign cm_A_i = in_A_i;
  assign cm_B_r = in_B_r;
  assign cm_B_i = in_B_i;

  // rdy_en_q keeps in_ready low during reset and for the release cycle.
  assign in_ready = rdy_en_q & (state_q == RUN);
  assign first_s  = (k_q == KW'(0));

  assign out_valid    = out_valid_q;
  assign out_S_r      = out_s_r_q;
  assign out_S_i      = out_s_i_q;
  assign out_overflow = out_ovf_q;
  assign out_row      = out_row_q;
  assign out_last     = out_last_q;

  // Next-state, beat counter, row counter and VCMAC control decode.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    abs_d   = abs_q;
    beat_s  = 1'b0;
    cm_w_en = 1'b0;
    cm_mult = 1'b0;
    cm_acc  = 1'b0;
    cm_abs  = 1'b0;
    case (state_q)
      RUN: begin
        beat_s  = in_valid & rdy_en_q;
        cm_w_en = beat_s;
        cm_mult = beat_s & first_s;
        cm_acc  = beat_s & ~first_s;
        // abs mode is taken live on the first beat, then held for the row.
        if (!rdy_en_q) begin
          cm_abs = 1'b0;
        end else if (first_s) begin
          cm_abs = in_abs;
        end else begin
          cm_abs = abs_q;
        end
        if (beat_s) begin
          if (first_s) begin
            abs_d = in_abs;
          end else begin
            abs_d = abs_q;
          end
          if (k_q == K_LAST) begin
            k_d     = KW'(0);
            state_d = DRAIN;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = RUN;
          end
        end else begin
          k_d     = k_q;
          state_d = RUN;
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = RUN;
          row_d   = (row_q == M_LAST) ? RW'(0) : row_q + RW'(1);
        end else begin
          state_d = OUT;
          row_d   = row_q;
        end
      end
      default: begin
        state_d = RUN;
        k_d     = KW'(0);
      end
    endcase
  end

  // FSM state, beat counter, row counter and latched abs mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      k_q     <= KW'(0);
      row_q   <= RW'(0);
      abs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      abs_q   <= abs_d;
    end
  end

  // Input enable: rises on the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

`ifdef VCMAC_SEQ_OVF_STICKY_EN
  logic ovf_q;

  // Sticky overflow: cleared by the row's mult beat, then OR-ed each cycle.
  // Cycles before the mult beat are harmless because the mult beat clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (beat_s & first_s) begin
      ovf_q <= 1'b0;
    end else if (state_q != OUT) begin
      ovf_q <= ovf_q | cm_overflow;
    end else begin
      ovf_q <= ovf_q;
    end
  end

  // Include the DRAIN cycle's own flag in the captured value.
  assign ovf_cap_s = ovf_q | cm_overflow;
`else
  assign ovf_cap_s = cm_overflow;
`endif

  // Result capture at the end of DRAIN; the result is held until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_s_r_q   <= '0;
      out_s_i_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_row_q   <= RW'(0);
      out_last_q  <= 1'b0;
    end else if (state_q == DRAIN) begin
      out_valid_q <= 1'b1;
      out_s_r_q   <= cm_S_r;
      out_s_i_q   <= cm_S_i;
      out_ovf_q   <= ovf_cap_s;
      out_row_q   <= row_q;
      out_last_q  <= (row_q == M_LAST);
    end else if ((state_q == OUT) && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vcmac_seq.sv
module tb_vcmac_seq;

  localparam int DW = 32;
  localparam int NL = 2;
  localparam int KB = 3;
  localparam int MR = 2;

`ifdef VCMAC_SEQ_OVF_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_abs;
  logic [NL-1:0][DW-1:0] a_r, a_i, b_r, b_i;
  logic [NL-1:0][DW-1:0] cm_A_r, cm_A_i, cm_B_r, cm_B_i;
  logic cm_mult, cm_acc, cm_w_en, cm_abs, cm_overflow, ovf_force;
  logic [NL-1:0][DW-1:0] s_r, s_i;
  logic out_valid, out_ready, out_overflow, out_last;
  logic [NL-1:0][DW-1:0] out_S_r, out_S_i;
  logic [0:0] out_row;

  int checks = 0;
  int errors = 0;
  int exp_row = 0;

  always #5 clk = ~clk;

  assign cm_overflow = ovf_force;

  vcmac_seq #(.DATA_W(DW), .N(NL), .K(KB), .M(MR)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A_r(a_r), .in_A_i(a_i), .in_B_r(b_r), .in_B_i(b_i),
    .in_abs(in_abs),
    .cm_A_r(cm_A_r), .cm_A_i(cm_A_i), .cm_B_r(cm_B_r), .cm_B_i(cm_B_i),
    .cm_mult(cm_mult), .cm_acc(cm_acc), .cm_w_en(cm_w_en), .cm_abs(cm_abs),
    .cm_overflow(cm_overflow), .cm_S_r(s_r), .cm_S_i(s_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_S_r(out_S_r), .out_S_i(out_S_i),
    .out_overflow(out_overflow), .out_row(out_row), .out_last(out_last)
  );

  // Stand-in VCMAC: mult loads A*B, acc adds A*B, result registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_r <= '0;
      s_i <= '0;
    end else if (cm_w_en) begin
      for (int l = 0; l < NL; l++) begin
        s_r[l] <= (cm_mult ? 32'd0 : s_r[l]) + cm_A_r[l] * cm_B_r[l] - cm_A_i[l] * cm_B_i[l];
        s_i[l] <= (cm_mult ? 32'd0 : s_i[l]) + cm_A_r[l] * cm_B_i[l] + cm_A_i[l] * cm_B_r[l];
      end
    end
  end

  function automatic logic [DW-1:0] prod_r(input logic [DW-1:0] ar, ai, br, bi);
    return ar * br - ai * bi;
  endfunction

  function automatic logic [DW-1:0] prod_i(input logic [DW-1:0] ar, ai, br, bi);
    return ar * bi + ai * br;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int l = 0; l < NL; l++) begin
      a_r[l] = $urandom; a_i[l] = $urandom;
      b_r[l] = $urandom; b_i[l] = $urandom;
    end
  endtask

  // One full row: random bubbles, K beats, DRAIN, OUT with stall, handshake.
  task automatic run_row(input int max_bub, input int stall, input int ovf_beat,
                         input bit ovf_drain, input bit exp_ovf);
    logic [NL-1:0][DW-1:0] sr, si;
    logic row_abs;
    int nb;
    sr = '0; si = '0; row_abs = 1'b0;
    for (int b = 0; b < KB; b++) begin
      nb = (max_bub > 0) ? int'($urandom_range(max_bub, 0)) : 0;
      for (int j = 0; j < nb; j++) begin
        tick(); in_valid = 1'b0; in_abs = 1'($urandom); out_ready = 1'($urandom);
        ovf_force = 1'b0; rand_ops(); #1;
        chk("bubble_wen", 128'(cm_w_en), 128'(0));
        chk("bubble_rdy", 128'(in_ready), 128'(1));
        if (b > 0) chk("bubble_abs", 128'(cm_abs), 128'(row_abs));
      end
      tick(); in_valid = 1'b1; in_abs = 1'($urandom); out_ready = 1'b0;
      ovf_force = (b == ovf_beat); rand_ops(); #1;
      if (b == 0) row_abs = in_abs;
      chk("beat_wen", 128'(cm_w_en), 128'(1));
      chk("beat_mult", 128'(cm_mult), 128'(b == 0));
      chk("beat_acc", 128'(cm_acc), 128'(b != 0));
      chk("beat_abs", 128'(cm_abs), 128'(row_abs));
      chk("pass_ar", 128'(cm_A_r), 128'(a_r));
      chk("pass_ai", 128'(cm_A_i), 128'(a_i));
      chk("pass_br", 128'(cm_B_r), 128'(b_r));
      chk("pass_bi", 128'(cm_B_i), 128'(b_i));
      for (int l = 0; l < NL; l++) begin
        sr[l] = sr[l] + prod_r(a_r[l], a_i[l], b_r[l], b_i[l]);
        si[l] = si[l] + prod_i(a_r[l], a_i[l], b_r[l], b_i[l]);
      end
    end
    tick(); in_valid = 1'b1; in_abs = 1'($urandom); ovf_force = ovf_drain; rand_ops(); #1;
    chk("drain_rdy", 128'(in_ready), 128'(0));
    chk("drain_wen", 128'(cm_w_en), 128'(0));
    chk("drain_mult", 128'(cm_mult | cm_acc | cm_abs), 128'(0));
    chk("drain_oval", 128'(out_valid), 128'(0));
    tick(); ovf_force = 1'b0; #1;
    chk("out_valid", 128'(out_valid), 128'(1));
    chk("out_sr", 128'(out_S_r), 128'(sr));
    chk("out_si", 128'(out_S_i), 128'(si));
    chk("out_row", 128'(out_row), 128'(exp_row));
    chk("out_last", 128'(out_last), 128'(exp_row == MR - 1));
    chk("out_ovf", 128'(out_overflow), 128'(exp_ovf));
    for (int s = 0; s < stall; s++) begin
      tick(); in_valid = 1'b1; ovf_force = 1'($urandom); rand_ops(); #1;
      chk("hold_rdy", 128'(in_ready), 128'(0));
      chk("hold_wen", 128'(cm_w_en), 128'(0));
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_sr", 128'(out_S_r), 128'(sr));
      chk("hold_si", 128'(out_S_i), 128'(si));
      chk("hold_ovf", 128'(out_overflow), 128'(exp_ovf));
      chk("hold_row", 128'(out_row), 128'(exp_row));
    end
    tick(); out_ready = 1'b1; in_valid = 1'b1; ovf_force = 1'b0; rand_ops(); #1;
    chk("hs_rdy", 128'(in_ready), 128'(0));
    chk("hs_wen", 128'(cm_w_en), 128'(0));
    tick(); out_ready = 1'b0; in_valid = 1'b0; #1;
    chk("post_valid", 128'(out_valid), 128'(0));
    chk("post_rdy", 128'(in_ready), 128'(1));
    exp_row = (exp_row + 1) % MR;
  endtask

  typedef struct packed {
    logic v, abs, ordy;
    logic e_rdy, e_wen, e_mult, e_acc, e_abs, e_oval;
  } vec_t;

  vec_t tbl[9];
  logic [NL-1:0][DW-1:0] tsr, tsi;

  initial begin
    //          v     abs   ordy  rdy   wen   mult  acc   abs   oval
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b0; in_valid = 1'b1; in_abs = 1'b1; out_ready = 1'b0; ovf_force = 1'b0;
    a_r = '0; a_i = '0; b_r = '0; b_i = '0;

    // Reset held for three cycles with a beat offered.
    for (int c = 0; c < 3; c++) begin
      tick(); rand_ops(); #1;
      chk("rst_rdy", 128'(in_ready), 128'(0));
      chk("rst_ctl", 128'({cm_w_en, cm_mult, cm_acc, cm_abs}), 128'(0));
      chk("rst_out", 128'({out_valid, out_overflow, out_row, out_last}), 128'(0));
      chk("rst_sr", 128'(out_S_r), 128'(0));
    end
    tick(); rst = 1'b1; in_valid = 1'b0; #1;
    tick(); #1;
    chk("rel_rdy", 128'(in_ready), 128'(1));

    // K=3 row with bubbles and abs latched from beat 0.
    tsr = '0; tsi = '0;
    for (int i = 0; i < 9; i++) begin
      tick(); in_valid = tbl[i].v; in_abs = tbl[i].abs; out_ready = tbl[i].ordy;
      ovf_force = 1'b0; rand_ops(); #1;
      chk("tbl_rdy", 128'(in_ready), 128'(tbl[i].e_rdy));
      chk("tbl_wen", 128'(cm_w_en), 128'(tbl[i].e_wen));
      chk("tbl_mult", 128'(cm_mult), 128'(tbl[i].e_mult));
      chk("tbl_acc", 128'(cm_acc), 128'(tbl[i].e_acc));
      chk("tbl_abs", 128'(cm_abs), 128'(tbl[i].e_abs));
      chk("tbl_oval", 128'(out_valid), 128'(tbl[i].e_oval));
      for (int l = 0; l < NL; l++) begin
        if (tbl[i].e_mult) begin
          tsr[l] = prod_r(a_r[l], a_i[l], b_r[l], b_i[l]);
          tsi[l] = prod_i(a_r[l], a_i[l], b_r[l], b_i[l]);
        end else if (tbl[i].e_acc) begin
          tsr[l] = tsr[l] + prod_r(a_r[l], a_i[l], b_r[l], b_i[l]);
          tsi[l] = tsi[l] + prod_i(a_r[l], a_i[l], b_r[l], b_i[l]);
        end
      end
      if (tbl[i].e_oval) begin
        chk("tbl_sr", 128'(out_S_r), 128'(tsr));
        chk("tbl_si", 128'(out_S_i), 128'(tsi));
        chk("tbl_row", 128'({out_row, out_last, out_overflow}), 128'(0));
      end
    end
    exp_row = 1;

    // Row 1 with a 5-cycle stall (out_last), then wrap back to row 0.
    run_row(2, 5, -1, 1'b0, 1'b0);
    run_row(2, 0, -1, 1'b0, 1'b0);
    // Overflow only mid-row, then only in DRAIN, then a clean row.
    run_row(0, 0, 2, 1'b0, STICKY);
    run_row(0, 1, -1, 1'b1, 1'b1);
    run_row(0, 0, -1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      run_row(2, int'($urandom_range(3, 0)), -1, 1'b0, 1'b0);
    end

    // Reset in the middle of a row.
    tick(); in_valid = 1'b1; in_abs = 1'b0; rand_ops(); #1;
    chk("mr_mult0", 128'(cm_mult), 128'(1));
    tick(); in_valid = 1'b1; rand_ops(); #1;
    chk("mr_acc1", 128'(cm_acc), 128'(1));
    tick(); rst = 1'b0; in_valid = 1'b1; in_abs = 1'b1; #1;
    chk("mr_rdy", 128'(in_ready), 128'(0));
    chk("mr_ctl", 128'({cm_w_en, cm_mult, cm_acc, cm_abs}), 128'(0));
    chk("mr_out", 128'({out_valid, out_overflow, out_row, out_last}), 128'(0));
    chk("mr_sr", 128'(out_S_r), 128'(0));
    chk("mr_si", 128'(out_S_i), 128'(0));
    tick(); rst = 1'b1; in_valid = 1'b0; #1;
    exp_row = 0;
    run_row(0, 0, -1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
